// File: rtl/blink_monitor_pkg.sv
// Shared definitions for the blink monitor: FSM encodings that the blink
// generator's self-test also decodes from the monitor's debug state output.
package blink_monitor_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_LOW  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        ARM  = ST_ARM,
        HIGH = ST_HIGH,
        LOW  = ST_LOW
    } state_t;

endpackage

// File: rtl/blink_monitor_sync_edge.sv
// Multi-flop synchroniser for the monitored line plus one-cycle rise/fall
// strobes derived from the synchronised level.
module sync_edge
    import blink_monitor_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock_in,
    input  logic reset_n,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lvl_d;

    // sync_q[0] is the metastability-exposed flop; the last stage is the level.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            lvl_d  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            lvl_d  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign lvl  = sync_q[SYNC_STAGES-1];
    assign rise = lvl & ~lvl_d;
    assign fall = ~lvl & lvl_d;

endmodule

// File: rtl/blink_monitor.sv
// Measures high/low durations of each full period of an asynchronous blink
// line, publishes them on a valid/ready port and flags a stuck line.
module blink_monitor
    import blink_monitor_pkg::*;
#(
    parameter int CNT_W       = 24,
    parameter int TIMEOUT     = 12000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             blink_i,
    output logic [CNT_W-1:0] meas_high,
    output logic [CNT_W-1:0] meas_low,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic             stuck,
    output logic             stuck_level,
    output logic             overrun,
    output logic [1:0]       fsm_state
);

    // Handshake: a measurement transfers on any clock_in edge where
    // meas_valid && meas_ready; meas_high/meas_low never change while
    // meas_valid is high and the consumer has not accepted.

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] lo_cnt;
    logic [CNT_W-1:0] arm_cnt;
    logic             lvl;
    logic             rise;
    logic             fall;

    logic [CNT_W-1:0] hi_inc;
    logic [CNT_W-1:0] lo_inc;
    logic [CNT_W-1:0] arm_inc;
    logic             hi_hit;
    logic             lo_hit;
    logic             arm_hit;
    logic             publish;
    logic             accept;

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clock_in(clock_in),
        .reset_n (reset_n),
        .din     (blink_i),
        .lvl     (lvl),
        .rise    (rise),
        .fall    (fall)
    );

    // A hit means this cycle would bring the counter to TIMEOUT.
    always_comb begin
        hi_inc  = (hi_cnt  == CNT_MAX) ? hi_cnt  : hi_cnt  + CNT_ONE;
        lo_inc  = (lo_cnt  == CNT_MAX) ? lo_cnt  : lo_cnt  + CNT_ONE;
        arm_inc = (arm_cnt == CNT_MAX) ? arm_cnt : arm_cnt + CNT_ONE;
        hi_hit  = (hi_cnt  >= TO_LAST);
        lo_hit  = (lo_cnt  >= TO_LAST);
        arm_hit = (arm_cnt >= TO_LAST);
        publish = enable && (state == LOW) && rise;
        accept  = meas_valid && meas_ready;
    end

    // Edges are tested before timeouts so a coincident edge always wins.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            hi_cnt      <= '0;
            lo_cnt      <= '0;
            arm_cnt     <= '0;
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
        end else if (!enable) begin
            state       <= IDLE;
            hi_cnt      <= '0;
            lo_cnt      <= '0;
            arm_cnt     <= '0;
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state   <= ARM;
                    arm_cnt <= '0;
                end
                ARM: begin
                    if (rise) begin
                        state   <= HIGH;
                        hi_cnt  <= CNT_ONE;
                        lo_cnt  <= '0;
                        arm_cnt <= '0;
                        stuck   <= 1'b0;
                    end else if (arm_hit) begin
                        stuck       <= 1'b1;
                        stuck_level <= lvl;
                        arm_cnt     <= '0;
                    end else begin
                        arm_cnt <= arm_inc;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state  <= LOW;
                        lo_cnt <= CNT_ONE;
                    end else if (hi_hit) begin
                        state       <= ARM;
                        stuck       <= 1'b1;
                        stuck_level <= lvl;
                        hi_cnt      <= '0;
                        lo_cnt      <= '0;
                        arm_cnt     <= '0;
                    end else begin
                        hi_cnt <= hi_inc;
                    end
                end
                LOW: begin
                    if (rise) begin
                        state  <= HIGH;
                        hi_cnt <= CNT_ONE;
                        lo_cnt <= '0;
                        stuck  <= 1'b0;
                    end else if (lo_hit) begin
                        state       <= ARM;
                        stuck       <= 1'b1;
                        stuck_level <= lvl;
                        hi_cnt      <= '0;
                        lo_cnt      <= '0;
                        arm_cnt     <= '0;
                    end else begin
                        lo_cnt <= lo_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The measurement values survive a disable so software can still read them.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            meas_high  <= '0;
            meas_low   <= '0;
            meas_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (!enable) begin
            meas_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (publish) begin
            if (!meas_valid || meas_ready) begin
                meas_high  <= hi_cnt;
                meas_low   <= lo_cnt;
                meas_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (accept) begin
            meas_valid <= 1'b0;
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_blink_monitor.sv
// Directed bench for blink_monitor: one instance at TIMEOUT=50 for the
// main scenarios and one narrow instance (CNT_W=4, TIMEOUT=15).
module tb_blink_monitor;

    logic        clk;
    logic        rst_n;
    logic        en_a;
    logic        en_b;
    logic        blink;
    logic        ready;

    logic [23:0] a_high;
    logic [23:0] a_low;
    logic        a_valid;
    logic        a_stuck;
    logic        a_stuck_level;
    logic        a_overrun;
    logic [1:0]  a_state;

    logic [3:0]  b_high;
    logic [3:0]  b_low;
    logic        b_valid;
    logic        b_stuck;
    logic        b_stuck_level;
    logic        b_overrun;
    logic [1:0]  b_state;

    int n_checks   = 0;
    int n_fail     = 0;
    int valid_seen = 0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    blink_monitor #(.CNT_W(24), .TIMEOUT(50), .SYNC_STAGES(2)) dut_a (
        .clock_in   (clk),
        .reset_n    (rst_n),
        .enable     (en_a),
        .blink_i    (blink),
        .meas_high  (a_high),
        .meas_low   (a_low),
        .meas_valid (a_valid),
        .meas_ready (ready),
        .stuck      (a_stuck),
        .stuck_level(a_stuck_level),
        .overrun    (a_overrun),
        .fsm_state  (a_state)
    );

    blink_monitor #(.CNT_W(4), .TIMEOUT(15), .SYNC_STAGES(2)) dut_b (
        .clock_in   (clk),
        .reset_n    (rst_n),
        .enable     (en_b),
        .blink_i    (blink),
        .meas_high  (b_high),
        .meas_low   (b_low),
        .meas_valid (b_valid),
        .meas_ready (ready),
        .stuck      (b_stuck),
        .stuck_level(b_stuck_level),
        .overrun    (b_overrun),
        .fsm_state  (b_state)
    );

    // driver tasks: every step ends 1 time unit after a rising edge
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (a_valid === 1'b1) valid_seen++;
        end
    endtask

    task automatic hold(input logic level, input int n);
        blink = level;
        tick(n);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; blink = 1'b0; ready = 1'b0;
        tick(3);
        check("rst_valid",   32'(a_valid), 0);
        check("rst_high",    32'(a_high), 0);
        check("rst_low",     32'(a_low), 0);
        check("rst_stuck",   32'(a_stuck), 0);
        check("rst_stk_lvl", 32'(a_stuck_level), 0);
        check("rst_overrun", 32'(a_overrun), 0);
        check("rst_state",   32'(a_state), 0);
        rst_n = 1'b1;
        tick(2);
        en_a = 1'b1; ready = 1'b1;
        tick(1);
        check("en_arm", 32'(a_state), 1);

        // Test 1: warm-up 4/4 period, then reset while in HIGH
        hold(1, 4); hold(0, 4); hold(1, 2);
        check("t1_first_rise_no_pub", 32'(a_valid), 0);
        hold(1, 1);
        check("t1_warm_valid", 32'(a_valid), 1);
        check("t1_warm_high",  32'(a_high), 4);
        check("t1_warm_state", 32'(a_state), 2);
        rst_n = 1'b0; blink = 1'b0;
        #1;
        check("t1_rst_valid", 32'(a_valid), 0);
        check("t1_rst_high",  32'(a_high), 0);
        check("t1_rst_low",   32'(a_low), 0);
        check("t1_rst_state", 32'(a_state), 0);
        tick(3);
        rst_n = 1'b1;
        hold(0, 2);
        hold(1, 4); hold(0, 4); hold(1, 2);
        check("t1_no_partial", 32'(a_valid), 0);
        hold(1, 1);
        check("t1_valid", 32'(a_valid), 1);
        check("t1_high",  32'(a_high), 4);
        check("t1_low",   32'(a_low), 4);

        // Test 2: streaming 10/6 with ready held high
        valid_seen = 0;
        hold(1, 1);
        check("t2_accept_drop", 32'(a_valid), 0);
        hold(1, 6); hold(0, 6); hold(1, 2);
        check("t2_latency_pre", 32'(a_valid), 0);
        hold(1, 1);
        check("t2_valid",  32'(a_valid), 1);
        check("t2_high",   32'(a_high), 10);
        check("t2_low",    32'(a_low), 6);
        check("t2_pulses", 32'(valid_seen), 1);
        valid_seen = 0;
        hold(1, 7); hold(0, 6); hold(1, 3);
        check("t2b_high",   32'(a_high), 10);
        check("t2b_low",    32'(a_low), 6);
        check("t2b_pulses", 32'(valid_seen), 1);

        // Test 3: consumer stalls; later periods differ so a lost hold shows up
        hold(1, 1);
        ready = 1'b0;
        hold(1, 6); hold(0, 6); hold(1, 3);
        check("t3_p1_valid",   32'(a_valid), 1);
        check("t3_p1_high",    32'(a_high), 10);
        check("t3_p1_overrun", 32'(a_overrun), 0);
        hold(1, 6); hold(0, 5); hold(1, 3);
        check("t3_p2_overrun", 32'(a_overrun), 1);
        check("t3_p2_valid",   32'(a_valid), 1);
        check("t3_p2_high",    32'(a_high), 10);
        check("t3_p2_low",     32'(a_low), 6);
        hold(1, 8); hold(0, 7); hold(1, 3);
        check("t3_p3_high", 32'(a_high), 10);
        check("t3_p3_low",  32'(a_low), 6);
        ready = 1'b1;
        hold(1, 1);
        check("t3_xfer_drop",  32'(a_valid), 0);
        check("t3_ovr_sticky", 32'(a_overrun), 1);

        // Test 6: disable while valid and overrun are both set
        ready = 1'b0;
        hold(1, 2); hold(0, 3); hold(1, 3);
        check("t6_pre_valid", 32'(a_valid), 1);
        check("t6_pre_high",  32'(a_high), 6);
        check("t6_pre_low",   32'(a_low), 3);
        en_a = 1'b0;
        hold(1, 1);
        check("t6_dis_valid",   32'(a_valid), 0);
        check("t6_dis_overrun", 32'(a_overrun), 0);
        check("t6_dis_stuck",   32'(a_stuck), 0);
        check("t6_dis_high",    32'(a_high), 6);
        check("t6_dis_low",     32'(a_low), 3);
        check("t6_dis_state",   32'(a_state), 0);
        en_a = 1'b1;
        hold(1, 1);
        check("t6_reen_arm", 32'(a_state), 1);
        ready = 1'b1;
        hold(1, 3); hold(0, 4); hold(1, 3);
        check("t6_no_partial", 32'(a_valid), 0);
        check("t6_now_high",   32'(a_state), 2);
        hold(1, 2); hold(0, 5); hold(1, 3);
        check("t6_valid", 32'(a_valid), 1);
        check("t6_high",  32'(a_high), 5);
        check("t6_low",   32'(a_low), 5);

        // Test 4: line stuck high after a rise (TIMEOUT=50)
        hold(1, 48);
        check("t4_pre_stuck", 32'(a_stuck), 0);
        hold(1, 1);
        check("t4_stuck",     32'(a_stuck), 1);
        check("t4_stuck_lvl", 32'(a_stuck_level), 1);
        check("t4_state_arm", 32'(a_state), 1);
        check("t4_no_pub",    32'(a_valid), 0);
        hold(1, 5); hold(0, 4); hold(1, 2);
        check("t4_stuck_held", 32'(a_stuck), 1);
        hold(1, 1);
        check("t4_stuck_clr", 32'(a_stuck), 0);
        check("t4_clr_nopub", 32'(a_valid), 0);
        hold(1, 2); hold(0, 5); hold(1, 3);
        check("t4_valid", 32'(a_valid), 1);
        check("t4_high",  32'(a_high), 5);
        check("t4_low",   32'(a_low), 5);

        // ARM wait timeout with the line low
        en_a = 1'b0;
        hold(0, 1);
        check("arm_to_idle", 32'(a_state), 0);
        en_a = 1'b1;
        hold(0, 50);
        check("arm_to_pre", 32'(a_stuck), 0);
        hold(0, 1);
        check("arm_to_stuck", 32'(a_stuck), 1);
        check("arm_to_lvl",   32'(a_stuck_level), 0);
        en_a = 1'b0;

        // Test 5: narrow instance, CNT_W=4 TIMEOUT=15
        en_b = 1'b1;
        hold(0, 2);
        check("t5_arm", 32'(b_state), 1);
        hold(1, 16);
        check("t5_pre_stuck", 32'(b_stuck), 0);
        hold(1, 1);
        check("t5_stuck",     32'(b_stuck), 1);
        check("t5_stuck_lvl", 32'(b_stuck_level), 1);
        check("t5_state_arm", 32'(b_state), 1);
        hold(1, 3); hold(0, 3); hold(1, 2);
        check("t5_stuck_held", 32'(b_stuck), 1);
        hold(1, 1);
        check("t5_stuck_clr", 32'(b_stuck), 0);
        check("t5_no_pub",    32'(b_valid), 0);
        hold(1, 11); hold(0, 1); hold(1, 3);
        check("t5_valid", 32'(b_valid), 1);
        check("t5_high",  32'(b_high), 14);
        check("t5_low",   32'(b_low), 1);
        check("t5_overrun", 32'(b_overrun), 0);

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/blink_monitor.md
Name: blink_monitor

Overview:
Receive-side counterpart of the blink generator. Samples an asynchronous blink/pulse line, synchronises it, and measures each full period's high and low durations in clock_in cycles. Presents each completed period on a valid/ready output port and flags a stuck line. Sits beside the main blink/timing logic on the XuLA board, used for loopback self-test and for monitoring externally timed strobes.

Parameters:
CNT_W, 24, width of the duration counters and measurement outputs.
TIMEOUT, 12000000, cycles in one phase before the line is declared stuck (1 s at 12 MHz); legal range 2..2^CNT_W-1.
SYNC_STAGES, 2, flip-flops in the input synchroniser; minimum 2.

Ports:
clock_in  in  1  sole clock; all logic on its rising edge.
reset_n  in  1  asynchronous, active-low reset.
enable  in  1  synchronous run enable; low forces IDLE.
blink_i  in  1  asynchronous monitored line.
meas_high  out  CNT_W  cycles the line was high in the last completed period.
meas_low  out  CNT_W  cycles the line was low in the last completed period.
meas_valid  out  1  meas_high/meas_low hold a measurement.
meas_ready  in  1  consumer accepts the measurement when meas_valid && meas_ready.
stuck  out  1  no edge seen for TIMEOUT cycles in the current phase.
stuck_level  out  1  synchronised line level when stuck was raised.
overrun  out  1  sticky; a completed period was dropped because the output was full.

Behaviour:
- Reset (async, reset_n=0): all outputs 0, FSM=IDLE, counters 0, synchroniser flops 0, previous-level flop 0.
- Sync: blink_i passes through SYNC_STAGES flops to give lvl. rise = lvl & ~lvl_d; fall = ~lvl & lvl_d.
- FSM states: IDLE, ARM, HIGH, LOW.
  IDLE: enable=1 -> ARM.
  ARM: wait for rise -> HIGH, hi_cnt=1.
  HIGH: hi_cnt++ each cycle with lvl=1; fall -> LOW, lo_cnt=1.
  LOW: lo_cnt++ each cycle with lvl=0; rise -> publish {hi_cnt, lo_cnt}, then HIGH with hi_cnt=1 and lo_cnt=0.
- A blink_i high for exactly N cycles and then low for M cycles yields meas_high=N and meas_low=M.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Latency: meas_valid rises on the SYNC_STAGES-th clock edge after the edge that first samples blink_i high at the end of the period.
- Publish:
  - If meas_valid=0, or meas_valid=1 with meas_ready=1 in the same cycle, load the outputs and set meas_valid=1.
  - Otherwise the outputs stay stable, the new result is dropped, and overrun is set.
- Accept without a new publish: meas_valid clears on the next edge.
- Stuck detection:
  - In HIGH or LOW, the active counter reaching TIMEOUT sets stuck=1, latches stuck_level=lvl, and sends the FSM to ARM with counters cleared.
  - In ARM, a TIMEOUT-cycle wait without rise sets stuck the same way; ARM uses a separate wait counter.
  - stuck clears on the next rise.
  - The partial period that timed out is never published.
- enable=0 (any state, synchronous):
  - FSM goes to IDLE; counters, meas_valid, stuck, stuck_level and overrun clear.
  - meas_high and meas_low keep their value.
  - The synchroniser keeps running.
- The first period after enable or after a stuck event always starts at a rise. A line that is already high at enable waits for a fall and then a rise.
- Simultaneous rise and timeout in one cycle: the edge wins and no stuck is raised.

Decomposition:
- Shared header carries the FSM state encodings (IDLE=0, ARM=1, HIGH=2, LOW=3) as localparams for reuse by the blink generator's self-test.
- One sub-module, sync_edge, contains the SYNC_STAGES synchroniser, lvl_d, and the rise/fall outputs. It is parameterised by SYNC_STAGES and has the same clock_in/reset_n.

Test Plan:
1. Reset mid-period (reset_n low for 3 cycles while in HIGH) -> all outputs 0 immediately; the next full 4-high/4-low period gives meas_high=4, meas_low=4.
2. enable=1, blink_i 10 cycles high / 6 low, repeated, meas_ready=1 -> meas_valid pulses once per 16 cycles with meas_high=10, meas_low=6, two edges after each rising sample.
3. meas_ready=0 across three periods (10/6) -> first result held stable, overrun=1 after the second period; on meas_ready=1, one transfer occurs and meas_valid then drops.
4. TIMEOUT=50, blink_i held high after a rise -> stuck=1 with stuck_level=1 after 50 high cycles and no meas_valid; the next rise clears stuck; the following 5/5 period reports 5/5.
5. CNT_W=4, TIMEOUT=15, 20-high/3-low period -> stuck raised at 15 cycles, nothing published; then CNT_W=4, TIMEOUT=15, 14-high/1-low period -> meas_high=14, meas_low=1.
6. enable dropped while meas_valid=1 and overrun=1 -> next edge: meas_valid=0, overrun=0, stuck=0, meas_high/meas_low unchanged; re-enable with the line already high -> no output until a full rise-to-rise period.
